add_share_ctrl: RTL and testbench



---
 rtl/add_share_ctrl_pkg.sv | 25 ++
 rtl/add_share_ctrl_rr_pick.sv | 27 ++
 rtl/add_share_ctrl.sv | 132 +++++++++++++
 tb/tb_add_share_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/add_share_ctrl_pkg.sv
// Shared types and constants for the four-way shared 8-bit adder controller.
package add_share_ctrl_pkg;

   localparam int unsigned W     = 8;
   localparam int unsigned N_REQ = 4;
   localparam int unsigned ID_W  = 2;
   localparam int unsigned BUS_W = W * N_REQ;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Operand pair latched from the winning requester
   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } operands_t;

   function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
      return N_REQ'(1) << id;
   endfunction

endpackage

// File: rtl/add_share_ctrl_rr_pick.sv
// Round-robin winner search: first set request at or above ptr, wrapping modulo N_REQ.
module add_share_ctrl_rr_pick
   import add_share_ctrl_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             any,
   output logic [ID_W-1:0]  win_id
);

   logic [ID_W-1:0] idx;

   // Scan from farthest to nearest offset so the nearest set bit wins
   always_comb begin
      any    = 1'b0;
      win_id = '0;
      idx    = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = ptr + ID_W'(i);
         if (req[idx]) begin
            any    = 1'b1;
            win_id = idx;
         end
      end
   end

endmodule

// File: rtl/add_share_ctrl.sv
// Round-robin controller sharing one 8-bit adder among four requesters; one result per 3 cycles.
module add_share_ctrl
   import add_share_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [N_REQ-1:0]  req,
   input  logic [BUS_W-1:0]  in1_bus,
   input  logic [BUS_W-1:0]  in2_bus,
   output logic [N_REQ-1:0]  grant,
   output logic              busy,
   output logic              done,
   output logic [W-1:0]      out,
   output logic              carry,
   output logic [ID_W-1:0]   out_id,
   output logic [W-1:0]      op_count
);

   state_t           state, state_nxt;
   logic [ID_W-1:0]  ptr_q, ptr_nxt;
   logic [ID_W-1:0]  win_q, win_nxt;
   operands_t        ops_q, ops_nxt;
   logic [W-1:0]     sum_q, sum_nxt;
   logic             cy_q, cy_nxt;

   logic [N_REQ-1:0] grant_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic [W-1:0]     out_nxt;
   logic             carry_nxt;
   logic [ID_W-1:0]  out_id_nxt;
   logic [W-1:0]     op_count_nxt;

   logic             pick_any;
   logic [ID_W-1:0]  pick_id;

   add_share_ctrl_rr_pick u_rr_pick (
      .req    (req),
      .ptr    (ptr_q),
      .any    (pick_any),
      .win_id (pick_id)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and next-value logic; result fields publish on the edge that leaves DONE
   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr_q;
      win_nxt      = win_q;
      ops_nxt      = ops_q;
      sum_nxt      = sum_q;
      cy_nxt       = cy_q;
      grant_nxt    = grant;
      done_nxt     = 1'b0;
      out_nxt      = out;
      carry_nxt    = carry;
      out_id_nxt   = out_id;
      op_count_nxt = op_count;

      case (state)
         IDLE: begin
            if (pick_any) begin
               win_nxt   = pick_id;
               ops_nxt.a = in1_bus[pick_id*W +: W];
               ops_nxt.b = in2_bus[pick_id*W +: W];
               grant_nxt = id_onehot(pick_id);
               state_nxt = CALC;
            end
         end
         CALC: begin
            {cy_nxt, sum_nxt} = (W+1)'(ops_q.a) + (W+1)'(ops_q.b);
            state_nxt         = DONE;
         end
         DONE: begin
            done_nxt     = 1'b1;
            out_nxt      = sum_q;
            carry_nxt    = cy_q;
            out_id_nxt   = win_q;
            ptr_nxt      = win_q + ID_W'(1);
            op_count_nxt = op_count + W'(1);
            grant_nxt    = '0;
            state_nxt    = IDLE;
         end
         default: begin
            grant_nxt = '0;
            state_nxt = IDLE;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q    <= '0;
         win_q    <= '0;
         ops_q    <= '0;
         sum_q    <= '0;
         cy_q     <= 1'b0;
         grant    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         out      <= '0;
         carry    <= 1'b0;
         out_id   <= '0;
         op_count <= '0;
      end else begin
         ptr_q    <= ptr_nxt;
         win_q    <= win_nxt;
         ops_q    <= ops_nxt;
         sum_q    <= sum_nxt;
         cy_q     <= cy_nxt;
         grant    <= grant_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         out      <= out_nxt;
         carry    <= carry_nxt;
         out_id   <= out_id_nxt;
         op_count <= op_count_nxt;
      end
   end

endmodule

// File: tb/tb_add_share_ctrl.sv
// Directed plus randomized bench for add_share_ctrl against a transaction-level reference model.
module tb_add_share_ctrl;

   logic        clk;
   logic        reset_n;
   logic [3:0]  req;
   logic [31:0] in1_bus;
   logic [31:0] in2_bus;
   logic [3:0]  grant;
   logic        busy;
   logic        done;
   logic [7:0]  out_s;
   logic        carry;
   logic [1:0]  out_id;
   logic [7:0]  op_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_done_cyc = 0;
   int last_gap = 0;
   int m_ptr = 0;
   int m_count = 0;

   add_share_ctrl dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .in1_bus  (in1_bus),
      .in2_bus  (in2_bus),
      .grant    (grant),
      .busy     (busy),
      .done     (done),
      .out      (out_s),
      .carry    (carry),
      .out_id   (out_id),
      .op_count (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Grant must never show more than one requester
   always @(negedge clk) begin
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
   end

   // Reference arbitration: first requester at or after ptr, wrapping
   function automatic int model_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge where done is high
   task automatic serve(input logic [3:0] r, input logic [31:0] a, input logic [31:0] b,
                        input bit keep, input bit scramble);
      int win, sa, sb, sum, n;
      win = model_pick(r, m_ptr);
      sa  = int'(a[8*win +: 8]);
      sb  = int'(b[8*win +: 8]);
      req = r; in1_bus = a; in2_bus = b;
      @(posedge clk);
      @(negedge clk);
      n = 1;
      check("grant", 32'(grant), 32'(1 << win));
      check("busy", 32'(busy), 32'd1);
      check("done_low", 32'(done), 32'd0);
      if (scramble) begin
         in1_bus = $urandom;
         in2_bus = $urandom;
      end
      @(negedge clk);
      n = 2;
      if (!keep) req[win] = 1'b0;
      while (!done && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("latency", 32'(n), 32'd3);
      check("done", 32'(done), 32'd1);
      sum = sa + sb;
      check("out", 32'(out_s), 32'(sum % 256));
      check("carry", 32'(carry), 32'(sum >= 256));
      check("out_id", 32'(out_id), 32'(win));
      m_count++;
      check("op_count", 32'(op_count), 32'(m_count % 256));
      check("grant_clr", 32'(grant), 32'd0);
      check("busy_clr", 32'(busy), 32'd0);
      m_ptr = (win + 1) % 4;
      last_gap = cyc - last_done_cyc;
      last_done_cyc = cyc;
   endtask

   initial begin
      logic [31:0] a, b;
      int exp_ids[5];
      exp_ids = '{0, 1, 2, 3, 0};
      reset_n = 1'b0; req = '0; in1_bus = '0; in2_bus = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_out", 32'(out_s), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single requester 2: 20 + 22
      a = $urandom; b = $urandom; a[23:16] = 8'd20; b[23:16] = 8'd22;
      serve(4'b0100, a, b, 1'b0, 1'b0);
      check("basic_out_42", 32'(out_s), 32'd42);

      // Overflow cases on requester 0
      a = $urandom; b = $urandom; a[7:0] = 8'd200; b[7:0] = 8'd100;
      serve(4'b0001, a, b, 1'b0, 1'b0);
      a[7:0] = 8'd255; b[7:0] = 8'd1;
      serve(4'b0001, a, b, 1'b0, 1'b0);
      check("ovf_carry", 32'(carry), 32'd1);

      // After serving 1 the pointer sits at 2, so 0 beats 1
      serve(4'b0010, $urandom, $urandom, 1'b0, 1'b0);
      serve(4'b0011, $urandom, $urandom, 1'b0, 1'b0);
      check("ptr_wrap_id", 32'(out_id), 32'd0);
      serve(4'b0010, $urandom, $urandom, 1'b0, 1'b0);

      // Operands changed after sampling are ignored
      serve(4'b1000, $urandom, $urandom, 1'b0, 1'b1);

      // All four held continuously: strict rotation, 3-cycle spacing
      for (int i = 0; i < 5; i++) begin
         serve(4'b1111, $urandom, $urandom, 1'b1, 1'b0);
         check("rot_id", 32'(out_id), 32'(exp_ids[i]));
         if (i > 0) check("done_gap", 32'(last_gap), 32'd3);
      end
      req = '0;
      repeat (2) @(negedge clk);

      // Reset during CALC aborts the transaction
      req = 4'b1000; in1_bus = $urandom; in2_bus = $urandom;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("arst_grant", 32'(grant), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_out", 32'(out_s), 32'd0);
      check("arst_carry", 32'(carry), 32'd0);
      check("arst_out_id", 32'(out_id), 32'd0);
      check("arst_op_count", 32'(op_count), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("arst_no_done", 32'(done), 32'd0);
      end
      reset_n = 1'b1;
      m_ptr = 0; m_count = 0;
      serve(4'b1000, $urandom, $urandom, 1'b0, 1'b0);
      check("restart_count", 32'(op_count), 32'd1);

      // Random traffic until op_count wraps
      for (int i = 0; i < 255; i++) begin
         serve(4'($urandom_range(1, 15)), $urandom, $urandom, 1'b0, 1'b0);
      end
      check("wrap", 32'(op_count), 32'd0);

      req = '0;
      repeat (4) @(negedge clk);
      check("idle_end", 32'(busy), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
